// File: rtl/soc_mem_pkg.sv
// Shared definitions for the core-to-SRAM bridge: load/store size codes,
// bridge FSM states and the post-reset instruction word.
package soc_mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic [31:0] RESET_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    IWAIT,
    DWAIT,
    RESP
  } bridge_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes/replicated data, load lane select
// with sign/zero extension, and alignment/size-code legality.
module lsu_align
  import soc_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  flag,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] lane_data,
  output logic [31:0] load_data,
  output logic        err
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    wstrb     = 4'b0000;
    lane_data = store_data;
    load_data = 32'h0;
    err       = 1'b0;
    case (flag)
      MEM_B, MEM_BU: begin
        wstrb     = 4'b0001 << addr_lo;
        lane_data = {4{store_data[7:0]}};
        load_data = (flag == MEM_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                    : {24'h0, shifted[7:0]};
      end
      MEM_H, MEM_HU: begin
        wstrb     = 4'b0011 << addr_lo;
        lane_data = {2{store_data[15:0]}};
        load_data = (flag == MEM_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                    : {16'h0, shifted[15:0]};
        err       = addr_lo[0];
      end
      MEM_W: begin
        wstrb     = 4'b1111;
        load_data = rdata;
        err       = (addr_lo != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_mem_bridge.sv
// Arbitrates rv32i_core fetch and load/store ports onto one synchronous
// SRAM word port; data requests win over fetch, every access ends in RESP.
module core_mem_bridge
  import soc_mem_pkg::*;
#(
  parameter int          MEM_WORDS   = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] RESET_INSTR = soc_mem_pkg::RESET_INSTR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  instr_addr,
  output logic [31:0]                  instr_data,
  output logic                         instr_ready,
  input  logic [31:0]                  mem_addr,
  input  logic [31:0]                  mem_wdata,
  input  logic [2:0]                   mem_flag,
  input  logic                         mem_we,
  input  logic                         mem_re,
  output logic [31:0]                  mem_data,
  output logic                         mem_ready,
  output logic                         misalign_err,
  output logic                         sram_en,
  output logic                         sram_we,
  output logic [$clog2(MEM_WORDS)-1:0] sram_addr,
  output logic [3:0]                   sram_wstrb,
  output logic [31:0]                  sram_wdata,
  input  logic [31:0]                  sram_rdata
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  bridge_state_t state, state_next;

  logic        data_req;
  logic [31:0] acc_addr;
  logic [32:0] offset;
  logic        range_ok;
  logic        acc_err;
  logic        issue;
  logic        issue_we;
  logic [3:0]  lane_strb;
  logic [31:0] lane_data;
  logic [31:0] load_ext;
  logic        align_err;

  lsu_align u_lsu_align (
    .addr_lo    (mem_addr[1:0]),
    .flag       (mem_flag),
    .store_data (mem_wdata),
    .rdata      (sram_rdata),
    .wstrb      (lane_strb),
    .lane_data  (lane_data),
    .load_data  (load_ext),
    .err        (align_err)
  );

  assign data_req = mem_we | mem_re;
  assign acc_addr = data_req ? mem_addr : instr_addr;
  // 33-bit offset so an address below BASE_ADDR shows up as a borrow.
  assign offset   = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
  assign range_ok = !offset[32] && (offset < MEM_BYTES);
  assign acc_err  = !range_ok || (data_req ? align_err : (instr_addr[1:0] != 2'b00));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    issue_we   = 1'b0;
    case (state)
      IDLE: begin
        if (acc_err) begin
          state_next = RESP;
        end else if (mem_we) begin
          issue      = 1'b1;
          issue_we   = 1'b1;
          state_next = RESP;
        end else if (mem_re) begin
          issue      = 1'b1;
          state_next = DWAIT;
        end else begin
          issue      = 1'b1;
          state_next = IWAIT;
        end
      end
      IWAIT, DWAIT: state_next = RESP;
      RESP:         state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  assign sram_en    = issue & ~rst;
  assign sram_we    = issue_we & ~rst;
  assign sram_wstrb = sram_we ? lane_strb : 4'b0000;
  assign sram_wdata = lane_data;
  assign sram_addr  = offset[AW+1:2];

  // Core-side results are registered; ready pulses line up with RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_data   <= RESET_INSTR;
      instr_ready  <= 1'b0;
      mem_data     <= 32'h0;
      mem_ready    <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      instr_ready <= 1'b0;
      mem_ready   <= 1'b0;
      case (state)
        IDLE: begin
          if (acc_err) begin
            misalign_err <= 1'b1;
            if (data_req) begin
              mem_data  <= 32'h0;
              mem_ready <= 1'b1;
            end else begin
              instr_data  <= 32'h0;
              instr_ready <= 1'b1;
            end
          end else if (mem_we) begin
            mem_ready <= 1'b1;
          end
        end
        IWAIT: begin
          instr_data  <= sram_rdata;
          instr_ready <= 1'b1;
        end
        DWAIT: begin
          mem_data  <= load_ext;
          mem_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/core_mem_bridge.md
# core_mem_bridge

Single-port memory bridge that sits directly below `rv32i_core` and serves both of its memory ports: instruction fetch (`instr_*`) and load/store (`mem_*`). Fetches and data accesses are arbitrated onto one synchronous SRAM word port. The bridge converts the core's `mem_flag` size/sign code into byte strobes and lane-shifted write data, and sign- or zero-extends load data. Every access completes with a one-cycle `*_ready` pulse.

## Interface

**Parameters**
- `MEM_WORDS`, default 4096: SRAM depth in 32-bit words.
- `BASE_ADDR`, default 32'h0000_0000: byte address mapped to SRAM word 0.
- `RESET_INSTR`, default 32'h0000_0013: `instr_data` value after reset (NOP).

**Ports**
- `clk`, in, 1: the single clock. The block has one clock; reset is asynchronous and active-high.
- `rst`, in, 1: asynchronous, active-high reset.
- `instr_addr`, in, 32: fetch byte address. A fetch is requested continuously.
- `instr_data`, out, 32: fetched word; holds its value between fetches.
- `instr_ready`, out, 1: one-cycle pulse when `instr_data` is updated.
- `mem_addr`, in, 32: load/store byte address.
- `mem_wdata`, in, 32: store data, right-aligned.
- `mem_flag`, in, 3: funct3 code. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- `mem_we`, in, 1: store request, held until `mem_ready`.
- `mem_re`, in, 1: load request, held until `mem_ready`.
- `mem_data`, out, 32: extended load result.
- `mem_ready`, out, 1: one-cycle completion pulse for loads and stores.
- `misalign_err`, out, 1: sticky error flag; cleared by reset only.
- `sram_en`, out, 1: SRAM access enable.
- `sram_we`, out, 1: SRAM write enable.
- `sram_addr`, out, $clog2(MEM_WORDS): SRAM word address.
- `sram_wstrb`, out, 4: SRAM byte-write strobes.
- `sram_wdata`, out, 32: SRAM write data.
- `sram_rdata`, in, 32: SRAM read data, valid the cycle after a read.

## Operation

**FSM states:** IDLE, IWAIT, DWAIT, RESP.

**IDLE.** Data requests take priority over fetch.
- `mem_we` asserted: issue an SRAM write this cycle, then go to RESP.
- `mem_re` asserted: issue an SRAM read, then go to DWAIT.
- Neither asserted: issue a fetch read at `instr_addr`, then go to IWAIT.
- `mem_we` and `mem_re` both asserted: treat as a store.

**IWAIT / DWAIT.**
- Register `sram_rdata`. In DWAIT the data passes through the load extender first.
- Go to RESP.

**RESP.**
- Exactly one of `instr_ready` or `mem_ready` is high, with its data already registered.
- Return to IDLE.
- The core must drop `mem_re`/`mem_we` before the next edge. A request still high in IDLE is a new access.

**Stores**
- `sram_wdata` = `mem_wdata` replicated across lanes.
- Strobes by size: B = 1 << addr[1:0]; H = 4'b0011 << addr[1:0]; W = 4'b1111.

**Loads**
- Select the lane from `addr[1:0]`.
- B/H: sign-extend. BU/HU: zero-extend.

**Address handling**
- `sram_addr` = (addr − BASE_ADDR) >> 2.

**Error conditions.** Each of the following is an error:
- Misaligned access: H with addr[0] = 1; W, or any fetch, with addr[1:0] ≠ 0.
- Illegal `mem_flag` (011, 110, 111).
- Address below BASE_ADDR, or at or above BASE_ADDR + 4·MEM_WORDS.

**Error response**
- `sram_en` stays low and the FSM goes IDLE → RESP.
- The ready pulse still fires. Load/fetch data is 0; a store is discarded.
- `misalign_err` is set.

## Timing

**Reset values**
- State: IDLE.
- `instr_data` = `RESET_INSTR`; `mem_data` = 0.
- `instr_ready`, `mem_ready`, `misalign_err`, `sram_en`, `sram_we` = 0.
- `sram_wstrb` = 0.

**Reset behaviour**
- `sram_en` and `sram_we` are gated by `!rst`, so no SRAM access occurs while `rst` is high.
- Reset mid-access aborts the access. No ready pulse is produced for it.

**Latency.** Request sampled in IDLE at cycle N:
- Load or fetch: `*_ready` high in cycle N+2.
- Store or error: `*_ready` high in cycle N+1.
- Next access is sampled at N+3 (load/fetch) or N+2 (store/error).

**Output drive**
- `sram_*` outputs are combinational from IDLE state and inputs.
- All core-side outputs are registered.

**Fetch priority.** Fetch waits behind back-to-back data accesses. Throughput with no data traffic is one fetch per 3 cycles.

## Structure

- Shared package `soc_mem_pkg` holds:
  - the `mem_flag` constants (`MEM_B`, `MEM_H`, `MEM_W`, `MEM_BU`, `MEM_HU`);
  - the FSM state enum;
  - `RESET_INSTR`.
- One combinational sub-module, `lsu_align`. Inputs: `addr[1:0]`, `mem_flag`, store data, SRAM read word. Outputs: strobes, lane data, extended load, misalign/illegal flag.
- The FSM, arbitration and range check live in `core_mem_bridge`.

## Test plan

1. **Reset/fetch.** Release reset with SRAM word 0 = 32'h0010_0093 and `instr_addr` = 0.
   - `instr_data` = 32'h13 until the first pulse.
   - `instr_ready` at cycle 2 with 32'h0010_0093.
2. **Sub-word stores then word load.**
   - SB 0xAA at 0x101, then SH 0xBEEF at 0x102, then LW at 0x100.
   - Strobes 4'b0010 and 4'b1100.
   - LW returns 32'hBEEF_AA00.
3. **Load extension** with word 32'h8081_F0F0 at 0x200:
   - LB 0x203 → 32'hFFFF_FF80.
   - LBU 0x203 → 32'h0000_0080.
   - LH 0x202 → 32'hFFFF_8081.
   - LHU 0x200 → 32'h0000_F0F0.
4. **Arbitration.** `mem_re` and a fetch are pending together in IDLE.
   - `mem_ready` fires first.
   - `instr_ready` fires 3 cycles later.
5. **Error path.** LW at 0x102, then SB at 4·MEM_WORDS.
   - `mem_ready` at N+1 with data 0.
   - `sram_en` stays 0 and `misalign_err` is set.
   - Memory is unchanged.
6. **Reset mid-access.** Assert `rst` in DWAIT.
   - No `mem_ready` pulse.
   - `sram_en` = 0 during reset.
   - After release, the first fetch completes normally.
